// File: rtl/rv_core_pkg.sv
// Shared integer-core constants and types used by the register file slice.
package rv_core_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_COUNT  = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: set on allocate, cleared by writeback, flushed on re-init.
module rf_scoreboard
    import rv_core_pkg::*;
#(
    parameter int unsigned DEPTH   = REG_COUNT,
    parameter int unsigned NUM_RD  = 2,
    parameter bit          ZERO_R0 = 1'b1,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     alloc_vld,
    input  logic [ADDR_W-1:0]        alloc_rd,
    input  logic                     clr0_vld,
    input  logic [ADDR_W-1:0]        clr0_addr,
    input  logic                     clr1_vld,
    input  logic [ADDR_W-1:0]        clr1_addr,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD-1:0]        rbusy
);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;

    // Allocation takes precedence over a same-edge writeback to the same register
    always_comb begin
        busy_nxt = busy;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            if (alloc_vld && (alloc_rd == ADDR_W'(r))) begin
                busy_nxt[r] = 1'b1;
            end else if ((clr0_vld && (clr0_addr == ADDR_W'(r))) ||
                         (clr1_vld && (clr1_addr == ADDR_W'(r)))) begin
                busy_nxt[r] = 1'b0;
            end
        end
        if (flush) begin
            busy_nxt = '0;
        end
        if (ZERO_R0) begin
            busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_comb begin
        rbusy = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rbusy[i] = busy[raddr[i*ADDR_W +: ADDR_W]];
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with two writeback ports, optional bypass,
// busy scoreboard and a sequential clear engine that zeroes the array.
module regfile_mp_sb
    import rv_core_pkg::*;
#(
    parameter int unsigned DATA_W  = XLEN,
    parameter int unsigned DEPTH   = REG_COUNT,
    parameter int unsigned NUM_RD  = 2,
    parameter bit          ZERO_R0 = 1'b1,
    parameter bit          BYPASS  = 1'b1,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init_req,
    output logic                     ready,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     alloc_vld,
    input  logic [ADDR_W-1:0]        alloc_rd
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e              state;
    state_e              state_nxt;
    logic [ADDR_W-1:0]   clr_idx;
    logic [ADDR_W-1:0]   clr_idx_nxt;
    logic                run;
    logic                wr0;
    logic                wr1;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   ra;
    logic [DATA_W-1:0]   rval;
    logic [NUM_RD-1:0]   sb_rbusy;

    assign run   = (state == RUN);
    assign ready = run;

    // Writes to x0 are discarded at the port so they neither store nor bypass
    assign wr0 = run && we0 && !(ZERO_R0 && (waddr0 == '0));
    assign wr1 = run && we1 && !(ZERO_R0 && (waddr1 == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= INIT;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        case (state)
            INIT: begin
                clr_idx_nxt = clr_idx + ADDR_W'(1);
                if (clr_idx == ADDR_W'(DEPTH - 1)) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (init_req) begin
                    state_nxt   = INIT;
                    clr_idx_nxt = '0;
                end
            end
        endcase
    end

    // WB1 is written last so it wins a same-address collision
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[clr_idx] <= '0;
        end else begin
            if (wr0) begin
                mem[waddr0] <= wdata0;
            end
            if (wr1) begin
                mem[waddr1] <= wdata1;
            end
        end
    end

    always_comb begin
        rdata = '0;
        ra    = '0;
        rval  = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            ra   = raddr[i*ADDR_W +: ADDR_W];
            rval = mem[ra];
            if (BYPASS && wr1 && (waddr1 == ra)) begin
                rval = wdata1;
            end else if (BYPASS && wr0 && (waddr0 == ra)) begin
                rval = wdata0;
            end
            if (!run || (ZERO_R0 && (ra == '0))) begin
                rval = '0;
            end
            rdata[i*DATA_W +: DATA_W] = rval;
        end
    end

    rf_scoreboard #(
        .DEPTH   (DEPTH),
        .NUM_RD  (NUM_RD),
        .ZERO_R0 (ZERO_R0)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .flush     (run && init_req),
        .alloc_vld (run && alloc_vld),
        .alloc_rd  (alloc_rd),
        .clr0_vld  (wr0),
        .clr0_addr (waddr0),
        .clr1_vld  (wr1),
        .clr1_addr (waddr1),
        .raddr     (raddr),
        .rbusy     (sb_rbusy)
    );

    assign rbusy = run ? sb_rbusy : '0;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: bypass/no-bypass pair on shared stimulus plus a
// 16x64, three-port instance checked against a reference model.
module tb_regfile_mp_sb;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    // Default-geometry pair (A: BYPASS=1, B: BYPASS=0), shared inputs
    logic        init_req, we0, we1, alloc_vld;
    logic [4:0]  waddr0, waddr1, alloc_rd;
    logic [31:0] wdata0, wdata1;
    logic [9:0]  raddr;
    logic        a_ready, b_ready;
    logic [63:0] a_rdata, b_rdata;
    logic [1:0]  a_rbusy, b_rbusy;

    // Sweep instance C: DEPTH=16, DATA_W=64, NUM_RD=3
    logic         c_init_req, c_we0, c_we1, c_alloc_vld;
    logic [3:0]   c_waddr0, c_waddr1, c_alloc_rd;
    logic [63:0]  c_wdata0, c_wdata1;
    logic [11:0]  c_raddr;
    logic         c_ready;
    logic [191:0] c_rdata;
    logic [2:0]   c_rbusy;

    regfile_mp_sb #(.BYPASS(1'b1)) u_a (
        .clk(clk), .rst(rst), .init_req(init_req), .ready(a_ready),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(a_rdata), .rbusy(a_rbusy),
        .alloc_vld(alloc_vld), .alloc_rd(alloc_rd)
    );

    regfile_mp_sb #(.BYPASS(1'b0)) u_b (
        .clk(clk), .rst(rst), .init_req(init_req), .ready(b_ready),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(b_rdata), .rbusy(b_rbusy),
        .alloc_vld(alloc_vld), .alloc_rd(alloc_rd)
    );

    regfile_mp_sb #(.DATA_W(64), .DEPTH(16), .NUM_RD(3)) u_c (
        .clk(clk), .rst(rst), .init_req(c_init_req), .ready(c_ready),
        .we0(c_we0), .waddr0(c_waddr0), .wdata0(c_wdata0),
        .we1(c_we1), .waddr1(c_waddr1), .wdata1(c_wdata1),
        .raddr(c_raddr), .rdata(c_rdata), .rbusy(c_rbusy),
        .alloc_vld(c_alloc_vld), .alloc_rd(c_alloc_rd)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        al;
        logic [4:0]  ard;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] ea0;
        logic [31:0] eb0;
        logic [31:0] ea1;
        logic [31:0] eb1;
        logic        bz0;
        logic        bz1;
    } vec_t;

    typedef struct {
        logic [63:0] d [3];
        logic [2:0]  b;
    } exp_t;

    vec_t        vecs [13];
    exp_t        exp_q [$];
    logic [63:0] mem_m [16];
    logic [15:0] busy_m;

    task automatic idle_ab();
        init_req = 1'b0; we0 = 1'b0; we1 = 1'b0; alloc_vld = 1'b0;
        waddr0 = '0; waddr1 = '0; alloc_rd = '0; wdata0 = '0; wdata1 = '0;
    endtask

    // Count edges after a clear starts; ready must rise exactly on edge `depth_a`
    task automatic wait_clear(input string tag);
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); #1;
            if (k == 15) check({tag, " c_ready_pre"}, 64'(c_ready), 64'd0);
            if (k == 16) check({tag, " c_ready_at16"}, 64'(c_ready), 64'd1);
            if (k == 31) begin
                check({tag, " a_ready_pre"}, 64'(a_ready), 64'd0);
                check({tag, " b_ready_pre"}, 64'(b_ready), 64'd0);
                check({tag, " a_rdata_init"}, a_rdata, 64'd0);
                check({tag, " a_rbusy_init"}, 64'(a_rbusy), 64'd0);
            end
        end
        check({tag, " a_ready_at32"}, 64'(a_ready), 64'd1);
        check({tag, " b_ready_at32"}, 64'(b_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1,5'd3,32'h11,       1'b1,5'd3,32'h22,       1'b0,5'd0, 5'd3, 5'd0, 32'h22,32'h0, 32'h0, 32'h0, 1'b0,1'b0};
        vecs[1]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd3, 5'd0, 32'h22,32'h22,32'h0, 32'h0, 1'b0,1'b0};
        vecs[2]  = '{1'b0,5'd0,32'h0,        1'b1,5'd0,32'hDEADBEEF, 1'b1,5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 32'h22,32'h22,1'b0,1'b0};
        vecs[3]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 32'h22,32'h22,1'b0,1'b0};
        vecs[4]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b1,5'd7, 5'd7, 5'd3, 32'h0, 32'h0, 32'h22,32'h22,1'b0,1'b0};
        vecs[5]  = '{1'b1,5'd7,32'h55,       1'b0,5'd0,32'h0,        1'b1,5'd7, 5'd7, 5'd0, 32'h55,32'h0, 32'h0, 32'h0, 1'b1,1'b0};
        vecs[6]  = '{1'b0,5'd0,32'h0,        1'b1,5'd7,32'h24,       1'b0,5'd0, 5'd7, 5'd7, 32'h24,32'h55,32'h24,32'h55,1'b1,1'b1};
        vecs[7]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd7, 5'd3, 32'h24,32'h24,32'h22,32'h22,1'b0,1'b0};
        vecs[8]  = '{1'b1,5'd4,32'hA4,       1'b1,5'd6,32'hB6,       1'b0,5'd0, 5'd4, 5'd6, 32'hA4,32'h0, 32'hB6,32'h0, 1'b0,1'b0};
        vecs[9]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd4, 5'd6, 32'hA4,32'hA4,32'hB6,32'hB6,1'b0,1'b0};
        vecs[10] = '{1'b1,5'd9,32'h85,       1'b0,5'd0,32'h0,        1'b1,5'd9, 5'd9, 5'd7, 32'h85,32'h0, 32'h24,32'h24,1'b0,1'b0};
        vecs[11] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd9, 5'd7, 32'h85,32'h85,32'h24,32'h24,1'b1,1'b0};
        vecs[12] = '{1'b1,5'd12,32'h99,      1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd12,5'd9, 32'h99,32'h0, 32'h85,32'h85,1'b0,1'b1};

        idle_ab();
        raddr = '0;
        c_init_req = 1'b0; c_we0 = 1'b0; c_we1 = 1'b0; c_alloc_vld = 1'b0;
        c_waddr0 = '0; c_waddr1 = '0; c_alloc_rd = '0; c_wdata0 = '0; c_wdata1 = '0;
        c_raddr = '0;

        // Reset, then a write attempt during the clear that must be ignored
        repeat (3) @(posedge clk);
        #1;
        check("rst a_ready", 64'(a_ready), 64'd0);
        check("rst c_ready", 64'(c_ready), 64'd0);
        check("rst a_rdata", a_rdata, 64'd0);
        rst = 1'b1;
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h87;
        raddr = {5'd0, 5'd5};
        wait_clear("boot");
        we0 = 1'b0;
        @(negedge clk);
        check("boot x5 ignored A", {32'h0, a_rdata[31:0]}, 64'd0);
        check("boot x5 ignored B", {32'h0, b_rdata[31:0]}, 64'd0);
        @(posedge clk); #1;

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            we0 = vecs[i].we0; waddr0 = vecs[i].wa0; wdata0 = vecs[i].wd0;
            we1 = vecs[i].we1; waddr1 = vecs[i].wa1; wdata1 = vecs[i].wd1;
            alloc_vld = vecs[i].al; alloc_rd = vecs[i].ard;
            raddr = {vecs[i].r1, vecs[i].r0};
            @(negedge clk);
            check($sformatf("vec%0d a_rdata0", i), {32'h0, a_rdata[31:0]},  {32'h0, vecs[i].ea0});
            check($sformatf("vec%0d b_rdata0", i), {32'h0, b_rdata[31:0]},  {32'h0, vecs[i].eb0});
            check($sformatf("vec%0d a_rdata1", i), {32'h0, a_rdata[63:32]}, {32'h0, vecs[i].ea1});
            check($sformatf("vec%0d b_rdata1", i), {32'h0, b_rdata[63:32]}, {32'h0, vecs[i].eb1});
            check($sformatf("vec%0d a_rbusy", i), 64'(a_rbusy), 64'({vecs[i].bz1, vecs[i].bz0}));
            check($sformatf("vec%0d b_rbusy", i), 64'(b_rbusy), 64'({vecs[i].bz1, vecs[i].bz0}));
            @(posedge clk); #1;
        end
        idle_ab();

        // init_req with x9 written and busy: clear everything, drop busy
        init_req = 1'b1;
        raddr = {5'd12, 5'd9};
        @(posedge clk); #1;
        init_req = 1'b0;
        check("initreq ready_drop", 64'(a_ready), 64'd0);
        check("initreq rbusy_drop", 64'(a_rbusy), 64'd0);
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk); #1;
        end
        check("initreq ready_pre", 64'(a_ready), 64'd0);
        @(posedge clk); #1;
        check("initreq ready_at32", 64'(a_ready), 64'd1);
        check("initreq x9 cleared", {32'h0, a_rdata[31:0]}, 64'd0);
        check("initreq x12 cleared", {32'h0, a_rdata[63:32]}, 64'd0);
        check("initreq busy cleared", 64'(a_rbusy), 64'd0);

        // rst pulled mid-clear at clr_idx=10 restarts the sequence
        we0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'h99;
        raddr = {5'd0, 5'd12};
        @(posedge clk); #1;
        we0 = 1'b0;
        @(negedge clk);
        check("x12 rewritten", {32'h0, a_rdata[31:0]}, 64'h99);
        @(posedge clk); #1;
        init_req = 1'b1;
        @(posedge clk); #1;
        init_req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midinit rst ready", 64'(a_ready), 64'd0);
        rst = 1'b1;
        wait_clear("midinit");
        @(negedge clk);
        check("midinit x12 cleared", {32'h0, a_rdata[31:0]}, 64'd0);
        @(posedge clk); #1;

        // Random sweep on the 16x64 three-port instance vs reference model
        for (int r = 0; r < 16; r++) mem_m[r] = '0;
        busy_m = '0;
        for (int n = 0; n < 300; n++) begin
            exp_t e;
            exp_t got;
            logic [3:0] ra [3];
            c_we0 = 1'($urandom_range(0, 1));
            c_we1 = 1'($urandom_range(0, 1));
            c_waddr0 = 4'($urandom_range(0, 15));
            c_waddr1 = ($urandom_range(0, 2) == 0) ? c_waddr0 : 4'($urandom_range(0, 15));
            c_wdata0 = {$urandom, $urandom};
            c_wdata1 = {$urandom, $urandom};
            c_alloc_vld = ($urandom_range(0, 2) == 0);
            c_alloc_rd = 4'($urandom_range(0, 15));
            for (int p = 0; p < 3; p++) begin
                case ($urandom_range(0, 3))
                    0: ra[p] = c_waddr0;
                    1: ra[p] = c_waddr1;
                    default: ra[p] = 4'($urandom_range(0, 15));
                endcase
            end
            c_raddr = {ra[2], ra[1], ra[0]};
            for (int p = 0; p < 3; p++) begin
                if (ra[p] == 4'd0) e.d[p] = '0;
                else if (c_we1 && c_waddr1 == ra[p]) e.d[p] = c_wdata1;
                else if (c_we0 && c_waddr0 == ra[p]) e.d[p] = c_wdata0;
                else e.d[p] = mem_m[ra[p]];
                e.b[p] = busy_m[ra[p]];
            end
            exp_q.push_back(e);

            @(negedge clk);
            if (exp_q.size() == 0) begin
                check("sweep queue empty", 64'd0, 64'd1);
            end else begin
                got = exp_q.pop_front();
                for (int p = 0; p < 3; p++) begin
                    check($sformatf("sweep%0d rdata%0d", n, p), c_rdata[p*64 +: 64], got.d[p]);
                    check($sformatf("sweep%0d rbusy%0d", n, p), 64'(c_rbusy[p]), 64'(got.b[p]));
                end
            end

            // Model update for the coming edge
            if (c_we0 && c_waddr0 != 4'd0) mem_m[c_waddr0] = c_wdata0;
            if (c_we1 && c_waddr1 != 4'd0) mem_m[c_waddr1] = c_wdata1;
            for (int r = 1; r < 16; r++) begin
                if (c_alloc_vld && c_alloc_rd == 4'(r)) busy_m[r] = 1'b1;
                else if ((c_we0 && c_waddr0 == 4'(r)) || (c_we1 && c_waddr1 == 4'(r))) busy_m[r] = 1'b0;
            end
            busy_m[0] = 1'b0;
            @(posedge clk); #1;
        end
        check("sweep c_ready", 64'(c_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
